// File: rtl/neuron_seq_ctrl.sv
// Single-neuron MAC sequencer: bias preload, N_INPUTS multiply-accumulates, saturating ReLU.
// Define NEURON_ACC_SAT_EN to clamp each accumulate step instead of wrapping.
module neuron_seq_ctrl #(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [20:0]       bias,
  output logic              rd_en,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [7:0]        x_data,
  input  logic [7:0]        w_data,
  output logic              busy,
  output logic              done,
  output logic [20:0]       acc_out,
  output logic [7:0]        y
);

  typedef enum logic [2:0] {StIdle, StRead, StDrain, StAct, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_INPUTS - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                valid_q;
  logic signed [20:0]  acc_q;

  logic signed [16:0]  x_ext;
  logic signed [16:0]  w_ext;
  logic signed [16:0]  prod;
  logic signed [20:0]  prod_ext;
  logic signed [20:0]  sum;
  logic signed [20:0]  acc_next;
  logic [7:0]          relu_y;

  assign x_addr = addr_q;
  assign w_addr = addr_q;

  // Activation is unsigned, so it is zero-extended before the signed multiply.
  always_comb begin
    x_ext    = {9'b0, x_data};
    w_ext    = {{9{w_data[7]}}, w_data};
    prod     = x_ext * w_ext;
    prod_ext = {{4{prod[16]}}, prod};
    sum      = acc_q + prod_ext;
`ifdef NEURON_ACC_SAT_EN
    if ((acc_q[20] == prod_ext[20]) && (sum[20] != acc_q[20])) begin
      acc_next = acc_q[20] ? 21'sh100000 : 21'sh0FFFFF;
    end else begin
      acc_next = sum;
    end
`else
    acc_next = sum;
`endif
  end

  always_comb begin
    relu_y = 8'd0;
    if (acc_q[20]) begin
      relu_y = 8'd0;
    end else if (acc_q[19:0] > 20'd127) begin
      relu_y = 8'd127;
    end else begin
      relu_y = {1'b0, acc_q[6:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      valid_q <= 1'b0;
      acc_q   <= '0;
      rd_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      acc_out <= '0;
      y       <= '0;
    end else begin
      done    <= 1'b0;
      // Memory data arrives one cycle after the read strobe.
      valid_q <= rd_en;
      if (valid_q) begin
        acc_q <= acc_next;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            acc_q   <= bias;
            addr_q  <= '0;
            rd_en   <= 1'b1;
            busy    <= 1'b1;
            state_q <= StRead;
          end
        end
        StRead: begin
          if (addr_q == LastAddr) begin
            rd_en   <= 1'b0;
            addr_q  <= '0;
            state_q <= StDrain;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        StDrain: begin
          state_q <= StAct;
        end
        StAct: begin
          acc_out <= acc_q;
          y       <= relu_y;
          done    <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Self-checking bench for neuron_seq_ctrl: directed test-plan cases plus randomized
// evaluations against a dot-product reference model.
module tb_neuron_seq_ctrl;

  localparam int N  = 4;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [20:0]   bias;
  logic          rd_en;
  logic [AW-1:0] x_addr;
  logic [AW-1:0] w_addr;
  logic [7:0]    x_data = 8'd0;
  logic [7:0]    w_data = 8'd0;
  logic          busy;
  logic          done;
  logic [20:0]   acc_out;
  logic [7:0]    y;

  int checks = 0;
  int errors = 0;

  logic [7:0] xmem [2**AW];
  logic [7:0] wmem [2**AW];

  logic          rd_tr   [32];
  logic [AW-1:0] xa_tr   [32];
  logic [AW-1:0] wa_tr   [32];
  logic          busy_tr [32];
  logic          done_tr [32];
  logic [20:0]   acc_tr  [32];
  logic [7:0]    y_tr    [32];
  int            done_q[$];

  neuron_seq_ctrl #(.N_INPUTS(N), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bias    (bias),
    .rd_en   (rd_en),
    .x_addr  (x_addr),
    .w_addr  (w_addr),
    .x_data  (x_data),
    .w_data  (w_data),
    .busy    (busy),
    .done    (done),
    .acc_out (acc_out),
    .y       (y)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories; junk is driven when not reading.
  always @(posedge clk) begin
    if (rd_en) begin
      x_data <= xmem[x_addr];
      w_data <= wmem[w_addr];
    end else begin
      x_data <= 8'($urandom);
      w_data <= 8'($urandom);
    end
  end

  function automatic logic [20:0] model_acc(input logic [20:0] b);
    longint a;
    logic [63:0] t;
    a = longint'($signed(b));
    for (int i = 0; i < N; i++) begin
      a = a + longint'(xmem[i]) * longint'($signed(wmem[i]));
`ifdef NEURON_ACC_SAT_EN
      if (a > 1048575) a = 1048575;
      else if (a < -1048576) a = -1048576;
`endif
    end
    t = 64'(a);
    return t[20:0];
  endfunction

  function automatic logic [7:0] model_relu(input logic [20:0] a);
    longint s;
    s = longint'($signed(a));
    if (s < 0) return 8'd0;
    if (s > 127) return 8'd127;
    return 8'(s);
  endfunction

  // Cycle 0 is the start cycle; pattern bit k drives start/rst for the edge ending cycle k.
  task automatic run_eval(input logic [20:0] b, input logic [20:0] b2, input int ncyc,
                          input logic [31:0] start_pat, input logic [31:0] rst_pat);
    done_q.delete();
    @(negedge clk);
    start = 1'b1;
    bias  = b;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      rd_tr[k]   = rd_en;
      xa_tr[k]   = x_addr;
      wa_tr[k]   = w_addr;
      busy_tr[k] = busy;
      done_tr[k] = done;
      acc_tr[k]  = acc_out;
      y_tr[k]    = y;
      if (done === 1'b1) done_q.push_back(k);
      start = start_pat[k];
      rst   = rst_pat[k];
      bias  = start_pat[k] ? b2 : 21'($urandom);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic load_mem(input int x0, input int x1, input int x2, input int x3,
                          input int w0, input int w1, input int w2, input int w3);
    xmem[0] = 8'(x0); xmem[1] = 8'(x1); xmem[2] = 8'(x2); xmem[3] = 8'(x3);
    wmem[0] = 8'(w0); wmem[1] = 8'(w1); wmem[2] = 8'(w2); wmem[3] = 8'(w3);
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b1;
    bias  = 21'd77;
    repeat (3) @(negedge clk);
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if (x_addr !== '0 || w_addr !== '0) begin
      errors++; $display("FAIL reset_addr got %0d/%0d want 0/0", x_addr, w_addr);
    end
    checks++; if (acc_out !== 21'd0) begin errors++; $display("FAIL reset_acc got %h want 0", acc_out); end
    checks++; if (y !== 8'd0) begin errors++; $display("FAIL reset_y got %0d want 0", y); end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    load_mem(10, 20, 30, 40, 1, 1, 1, 1);
    run_eval(21'd0, 21'd0, 9, 32'h0, 32'h0);
    checks++;
    if (done_q.size() != 1 || done_q[0] != N + 3) begin
      errors++; $display("FAIL basic_done_cycle count %0d first %0d want 1 at %0d",
                         done_q.size(), done_q.size() ? done_q[0] : -1, N + 3);
    end
    for (int k = 1; k <= N + 3; k++) begin
      checks++;
      if (rd_tr[k] !== (k <= N) || busy_tr[k] !== 1'b1) begin
        errors++; $display("FAIL basic_strobe cycle %0d rd_en %b busy %b want %b 1",
                           k, rd_tr[k], busy_tr[k], k <= N);
      end
      if (k <= N) begin
        checks++;
        if (xa_tr[k] !== AW'(k - 1) || wa_tr[k] !== AW'(k - 1)) begin
          errors++; $display("FAIL basic_addr cycle %0d got %0d/%0d want %0d",
                             k, xa_tr[k], wa_tr[k], k - 1);
        end
      end
    end
    checks++;
    if (busy_tr[N + 4] !== 1'b0 || done_tr[N + 4] !== 1'b0) begin
      errors++; $display("FAIL basic_idle busy %b done %b want 0 0", busy_tr[N + 4], done_tr[N + 4]);
    end
    checks++; if (acc_out !== 21'd100) begin errors++; $display("FAIL basic_acc got %0d want 100", acc_out); end
    checks++; if (y !== 8'd100) begin errors++; $display("FAIL basic_y got %0d want 100", y); end
  endtask

  task automatic test_vectors;
    load_mem(10, 20, 30, 40, -1, -1, -1, -1);
    run_eval(21'd0, 21'd0, 9, 32'h0, 32'h0);
    checks++; if (acc_out !== 21'h1FFF9C) begin errors++; $display("FAIL neg_acc got %h want 1fff9c", acc_out); end
    checks++; if (y !== 8'd0) begin errors++; $display("FAIL neg_y got %0d want 0", y); end

    load_mem(127, 127, 127, 127, 127, 127, 127, 127);
    run_eval(21'd0, 21'd0, 9, 32'h0, 32'h0);
    checks++; if (acc_out !== 21'd64516) begin errors++; $display("FAIL big_acc got %0d want 64516", acc_out); end
    checks++; if (y !== 8'd127) begin errors++; $display("FAIL big_y got %0d want 127", y); end

    load_mem(1, 1, 1, 1, 1, 1, 1, 1);
    run_eval(-21'sd50, -21'sd50, 9, 32'h0, 32'h0);
    checks++; if (acc_out !== 21'h1FFFD2) begin errors++; $display("FAIL bias_acc got %h want 1fffd2", acc_out); end
    checks++; if (y !== 8'd0) begin errors++; $display("FAIL bias_y got %0d want 0", y); end
  endtask

  task automatic test_overflow;
    logic [20:0] want_acc;
    logic [7:0]  want_y;
`ifdef NEURON_ACC_SAT_EN
    want_acc = 21'd1048575;
    want_y   = 8'd127;
`else
    want_acc = 21'h100063;
    want_y   = 8'd0;
`endif
    load_mem(10, 20, 30, 40, 1, 1, 1, 1);
    run_eval(21'd1048575, 21'd1048575, 9, 32'h0, 32'h0);
    checks++; if (acc_out !== want_acc) begin errors++; $display("FAIL ovf_acc got %h want %h", acc_out, want_acc); end
    checks++; if (y !== want_y) begin errors++; $display("FAIL ovf_y got %0d want %0d", y, want_y); end
  endtask

  task automatic test_reset_mid;
    load_mem(10, 20, 30, 40, 2, 2, 2, 2);
    run_eval(21'd5, 21'd5, 10, 32'h0, 32'h8);
    checks++; if (done_q.size() != 0) begin errors++; $display("FAIL abort_done got %0d pulses want 0", done_q.size()); end
    for (int k = 4; k <= 10; k++) begin
      checks++;
      if (busy_tr[k] !== 1'b0 || rd_tr[k] !== 1'b0 || acc_tr[k] !== 21'd0 || y_tr[k] !== 8'd0) begin
        errors++; $display("FAIL abort_outputs cycle %0d busy %b rd %b acc %h y %0d want 0 0 0 0",
                           k, busy_tr[k], rd_tr[k], acc_tr[k], y_tr[k]);
      end
    end
    // A start pulse mid-evaluation, with a different bias, must be ignored.
    run_eval(21'd5, 21'd999, 12, 32'h8, 32'h0);
    checks++;
    if (done_q.size() != 1 || done_q[0] != N + 3) begin
      errors++; $display("FAIL busy_start done count %0d first %0d want 1 at %0d",
                         done_q.size(), done_q.size() ? done_q[0] : -1, N + 3);
    end
    checks++; if (acc_out !== model_acc(21'd5)) begin errors++; $display("FAIL restart_acc got %0d want %0d", acc_out, model_acc(21'd5)); end
    checks++; if (y !== model_relu(model_acc(21'd5))) begin errors++; $display("FAIL restart_y got %0d want %0d", y, model_relu(model_acc(21'd5))); end
  endtask

  task automatic test_back_to_back;
    logic [20:0] a1;
    logic [20:0] a2;
    load_mem(10, 20, 30, 40, 1, 1, 1, 1);
    a1 = model_acc(21'd0);
    a2 = model_acc(-21'sd40);
    // Start held high: the second evaluation is accepted in the first IDLE cycle (8).
    run_eval(21'd0, -21'sd40, 17, 32'h1FF, 32'h0);
    checks++;
    if (done_q.size() != 2 || done_q[0] != 7 || done_q[1] != 15) begin
      errors++; $display("FAIL b2b_done count %0d first %0d second %0d want 2 at 7 15",
                         done_q.size(), done_q.size() > 0 ? done_q[0] : -1,
                         done_q.size() > 1 ? done_q[1] : -1);
    end
    checks++;
    if (acc_tr[7] !== a1 || y_tr[7] !== model_relu(a1)) begin
      errors++; $display("FAIL b2b_first acc %0d y %0d want %0d %0d", acc_tr[7], y_tr[7], a1, model_relu(a1));
    end
    checks++;
    if (acc_tr[15] !== a2 || y_tr[15] !== model_relu(a2)) begin
      errors++; $display("FAIL b2b_second acc %0d y %0d want %0d %0d", acc_tr[15], y_tr[15], a2, model_relu(a2));
    end
  endtask

  task automatic test_random;
    logic [20:0] b;
    logic [20:0] want;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < N; i++) begin
        xmem[i] = 8'($urandom);
        wmem[i] = 8'($urandom);
      end
      b = (it % 3 == 0) ? 21'($urandom) : 21'($urandom_range(0, 4000) - 2000);
      want = model_acc(b);
      run_eval(b, b, 9, 32'h0, 32'h0);
      checks++;
      if (done_q.size() != 1 || done_q[0] != N + 3 || acc_out !== want || y !== model_relu(want)) begin
        errors++; $display("FAIL random_%0d done %0d acc %h y %0d want acc %h y %0d",
                           it, done_q.size() ? done_q[0] : -1, acc_out, y, want, model_relu(want));
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bias  = '0;
    for (int i = 0; i < 2**AW; i++) begin
      xmem[i] = 8'd0;
      wmem[i] = 8'd0;
    end
    test_reset();
    test_basic();
    test_vectors();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
